// File: rtl/phy_types_pkg.sv
// rtl/phy_types_pkg.sv - Shared types and class index constants for the PHY TX arbiter
package phy_types_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    WAIT_PKT  = 2'd3
  } arb_state_t;

  // Request class indices; lower index wins under fixed priority
  localparam int unsigned ACK  = 0;
  localparam int unsigned NACK = 1;
  localparam int unsigned RS0  = 2;
  localparam int unsigned RS1  = 3;
  localparam int unsigned RS2  = 4;
  localparam int unsigned RS3  = 5;
  localparam int unsigned DATA = 6;

endpackage

// File: rtl/arb_class_counter.sv
// rtl/arb_class_counter.sv - Saturating up/down pending-request counter with full flag
module arb_class_counter #(
  parameter int COUNTER_SIZE = 4
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [COUNTER_SIZE-1:0] count_o,
  output logic                    full_o
);

  localparam logic [COUNTER_SIZE-1:0] MAX_CNT = '1;
  localparam logic [COUNTER_SIZE-1:0] ONE     = COUNTER_SIZE'(1);

  logic [COUNTER_SIZE-1:0] count_q, count_d;

  // Full flag is a pure decode of the registered count
  always_comb full_o = (count_q == MAX_CNT);

  // Simultaneous inc and dec cancel; inc into a full counter is dropped
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o)
      count_d = count_q + ONE;
    else if (dec_i && !inc_i && (count_q != '0))
      count_d = count_q - ONE;
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (!nrst_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/phy_tx_arbiter.sv
// rtl/phy_tx_arbiter.sv - PHY TX class arbiter; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module phy_tx_arbiter #(
  parameter int NUM_CLASSES  = 7,
  parameter int COUNTER_SIZE = 4,
  parameter int DATA_CLASS   = NUM_CLASSES - 1,
  localparam int SEL_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NUM_CLASSES-1:0] req_write,
  input  logic [7:0]             rx_header,
  input  logic                   done,
  input  logic                   packet_done,
  output logic [NUM_CLASSES-1:0] cnt_full,
  output logic                   start,
  output logic [SEL_W-1:0]       grant_sel,
  output logic                   get_data,
  output logic [7:0]             header_out,
  output logic                   busy
);

  import phy_types_pkg::*;

  arb_state_t              state_q, state_d;
  logic [SEL_W-1:0]        grant_q, grant_d;
  logic [7:0]              header_q, header_d;
  logic [COUNTER_SIZE-1:0] cnt [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]  dec_vec;
  logic                    any_pending;
  logic [SEL_W-1:0]        winner;

  // One pending counter per class; the class is decremented in its ISSUE cycle
  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
    assign dec_vec[i] = (state_q == ISSUE) && (grant_q == SEL_W'(i));
    arb_class_counter #(.COUNTER_SIZE(COUNTER_SIZE)) u_cnt (
      .clk_i   (CLK),
      .nrst_i  (nRST),
      .inc_i   (req_write[i]),
      .dec_i   (dec_vec[i]),
      .count_o (cnt[i]),
      .full_o  (cnt_full[i])
    );
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] last_q, last_d;
  int               idx;

  // Round-robin search starting just after the last granted class
  always_comb begin
    any_pending = 1'b0;
    winner      = '0;
    idx         = 0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM_CLASSES;
      if (!any_pending && (cnt[idx] != '0)) begin
        any_pending = 1'b1;
        winner      = SEL_W'(idx);
      end
    end
  end

  // Remember the class chosen at each IDLE decision
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_pending) last_d = winner;
  end

  // Last-grant pointer; resets so the first search begins at class 0
  always_ff @(posedge CLK) begin
    if (!nRST) last_q <= SEL_W'(NUM_CLASSES - 1);
    else       last_q <= last_d;
  end
`else
  // Fixed priority: lowest nonzero class index wins
  always_comb begin
    any_pending = 1'b0;
    winner      = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (!any_pending && (cnt[k] != '0)) begin
        any_pending = 1'b1;
        winner      = SEL_W'(k);
      end
    end
  end
`endif

  // FSM next state; completion strobes only matter in their own wait state
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    header_d = header_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          grant_d  = winner;
          header_d = rx_header;
          state_d  = ISSUE;
        end
      end
      ISSUE:     state_d = (grant_q == SEL_W'(DATA_CLASS)) ? WAIT_PKT : WAIT_DONE;
      WAIT_DONE: if (done)        state_d = IDLE;
      WAIT_PKT:  if (packet_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM and grant registers; reset abandons any grant in flight
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      header_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      header_q <= header_d;
    end
  end

  assign start      = (state_q == ISSUE);
  assign get_data   = (state_q == WAIT_PKT);
  assign busy       = (state_q != IDLE);
  assign grant_sel  = grant_q;
  assign header_out = header_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// tb/tb_phy_tx_arbiter.sv - Directed self-checking bench for phy_tx_arbiter
module tb_phy_tx_arbiter;

  logic       CLK;
  logic       nRST;
  logic [6:0] req_write;
  logic [7:0] rx_header;
  logic       done;
  logic       packet_done;
  logic [6:0] cnt_full;
  logic       start;
  logic [2:0] grant_sel;
  logic       get_data;
  logic [7:0] header_out;
  logic       busy;

  int n_checks;
  int n_fail;

  phy_tx_arbiter dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .req_write   (req_write),
    .rx_header   (rx_header),
    .done        (done),
    .packet_done (packet_done),
    .cnt_full    (cnt_full),
    .start       (start),
    .grant_sel   (grant_sel),
    .get_data    (get_data),
    .header_out  (header_out),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait for start, then complete a comma grant with a done pulse
  task automatic serve(input int max_wait, output logic found, output logic [2:0] sel);
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < max_wait && !found; i++) begin
      if (start === 1'b1) begin
        found = 1'b1;
        sel   = grant_sel;
      end else begin
        tick();
      end
    end
    if (found) begin
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
  endtask

  logic       found;
  logic [2:0] sel;
  int         starts;
  int         gd_bad;
  int         grants2;
  int         grants_all;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    nRST        = 1'b0;
    req_write   = '0;
    rx_header   = 8'h00;
    done        = 1'b0;
    packet_done = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy",     busy,       0);
    check("rst_start",    start,      0);
    check("rst_get_data", get_data,   0);
    check("rst_grant",    grant_sel,  0);
    check("rst_header",   header_out, 8'h00);
    check("rst_full",     cnt_full,   0);
    nRST = 1'b1;
    tick();

    // Single ACK request: start two edges after the write
    req_write = 7'b0000001;
    rx_header = 8'hA5;
    tick();
    req_write = '0;
    check("a_no_early_start", start, 0);
    tick();
    check("a_start",  start,      1);
    check("a_grant",  grant_sel,  0);
    check("a_header", header_out, 8'hA5);
    check("a_busy",   busy,       1);
    rx_header = 8'h3C;
    tick();
    check("a_wait_start", start,      0);
    check("a_hold_hdr",   header_out, 8'hA5);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("a_idle", busy, 0);
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (start === 1'b1) starts++;
      tick();
    end
    check("a_count_empty", starts, 0);

    // Data grant: done in ISSUE and WAIT_PKT is ignored
    req_write = 7'b1000000;
    tick();
    req_write = '0;
    tick();
    check("b_start", start,     1);
    check("b_grant", grant_sel, 6);
    done = 1'b1;
    tick();
    done = 1'b0;
    gd_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (get_data !== 1'b1) gd_bad++;
      done        = (i == 4);
      packet_done = (i == 9);
      tick();
    end
    done        = 1'b0;
    packet_done = 1'b0;
    check("b_get_data_10", gd_bad,   0);
    check("b_get_data_off", get_data, 0);
    check("b_idle",         busy,     0);

    // Saturation while held in WAIT_DONE on an ACK grant
    req_write = 7'b0000001;
    tick();
    req_write = '0;
    tick();
    check("c_hold_start", start, 1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      req_write = 7'b0000100;
      tick();
      if (i == 14) check("c_full_after_14", cnt_full[2], 0);
      if (i == 15) check("c_full_after_15", cnt_full[2], 1);
    end
    req_write = '0;
    check("c_full_after_16", cnt_full[2], 1);
    check("c_still_wait",    busy,        1);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("c_grant2_start", start,     1);
    check("c_grant2_sel",   grant_sel, 2);
    req_write = 7'b0000100;
    tick();
    req_write = '0;
    check("c_simul_full", cnt_full[2], 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    grants2    = 0;
    grants_all = 0;
    for (int i = 0; i < 20; i++) begin
      serve(4, found, sel);
      if (found) begin
        grants_all++;
        if (sel == 3'd2) grants2++;
        if (grants_all == 1) check("c_full_drop", cnt_full[2], 0);
      end
    end
    check("c_drain_class2", grants2,    15);
    check("c_drain_all",    grants_all, 15);

    // Priority between classes 1 and 3 after a class 2 grant
    req_write = 7'b0000100;
    tick();
    req_write = '0;
    serve(8, found, sel);
    check("d_prior_found", found, 1);
    check("d_prior_sel",   sel,   2);
    req_write = 7'b0001010;
    tick();
    req_write = '0;
    serve(8, found, sel);
    check("d_first_found", found, 1);
`ifdef ARB_ROUND_ROBIN_EN
    check("d_first_sel", sel, 3);
`else
    check("d_first_sel", sel, 1);
`endif
    serve(8, found, sel);
    check("d_second_found", found, 1);
`ifdef ARB_ROUND_ROBIN_EN
    check("d_second_sel", sel, 1);
`else
    check("d_second_sel", sel, 3);
`endif

    // Reset during WAIT_PKT with other classes pending
    req_write = 7'b1000000;
    tick();
    req_write = '0;
    tick();
    tick();
    check("e_in_pkt", get_data, 1);
    req_write = 7'b0000011;
    tick();
    req_write = '0;
    nRST = 1'b0;
    tick();
    check("e_get_data", get_data, 0);
    check("e_busy",     busy,     0);
    check("e_full",     cnt_full, 0);
    check("e_grant",    grant_sel, 0);
    nRST = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (start === 1'b1) starts++;
    end
    check("e_no_start", starts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
